// File: rtl/divider_4bit.sv
// 4-bit unsigned restoring divider: one quotient bit per RUN cycle, MSB first.
// Results are registered and presented with a one-cycle done pulse.
module divider_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  output logic       busy,
  output logic       done,
  output logic [3:0] quot,
  output logic [3:0] rem,
  output logic       div_zero
);

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;
  localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    dvd_q, dvd_d;   // dividend bits shifting out, quotient bits shifting in
  logic [W-1:0]    dvs_q, dvs_d;
  logic [W-1:0]    pr_q, pr_d;     // restored partial remainder, always < divisor
  logic            wz_q, wz_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    quot_q, quot_d;
  logic [W-1:0]    rem_q, rem_d;
  logic            dz_q, dz_d;

  logic [W:0]      shifted;
  logic            fits;
  logic [W-1:0]    diff;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start)                state_d = (in2 == '0) ? S_DONE : S_RUN;
        else if (state_q == S_DONE) state_d = S_IDLE;
      end
      S_RUN:   if (cnt_q == '0) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    pr_d   = pr_q;
    wz_d   = wz_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dz_d   = dz_q;

    // 5-bit trial value keeps the carry-out of the shift for the compare
    shifted = {pr_q, dvd_q[W-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    diff    = shifted[W-1:0] - dvs_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dvs_d = in2;
          wz_d  = (in2 == '0);
          if (in2 == '0) begin
            dvd_d = '1;
            pr_d  = in1;
          end else begin
            dvd_d = in1;
            pr_d  = '0;
            cnt_d = CNT_LOAD;
          end
        end
      end
      S_RUN: begin
        pr_d  = fits ? diff : shifted[W-1:0];
        dvd_d = {dvd_q[W-2:0], fits};
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      default: ;
    endcase

    // Results are published on the edge that leaves DONE
    if (state_q == S_DONE) begin
      quot_d = dvd_q;
      rem_d  = pr_q;
      dz_d   = wz_q;
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_q == S_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      pr_q   <= '0;
      wz_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      dz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      pr_q   <= pr_d;
      wz_q   <= wz_d;
      busy_q <= busy_d;
      done_q <= done_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dz_q   <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quot     = quot_q;
  assign rem      = rem_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_divider_4bit.sv
// Bench for divider_4bit: cycle-level reference model plus directed and random stimulus.
module tb_divider_4bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] in1;
  logic [3:0] in2;
  logic       busy;
  logic       done;
  logic [3:0] quot;
  logic [3:0] rem;
  logic       div_zero;

  int checks = 0;
  int errors = 0;

  divider_4bit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in1      (in1),
    .in2      (in2),
    .busy     (busy),
    .done     (done),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 'left' counts edges until done rises (5 for a real
  // division, 1 for a zero divisor); a new start is taken unless iterating.
  int         left;
  logic       m_done;
  logic [3:0] mq, mr, pq, pr;
  logic       mz, pz;
  bit         mvalid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      left   <= 0;
      m_done <= 1'b0;
      mq     <= '0;
      mr     <= '0;
      mz     <= 1'b0;
      mvalid <= 1'b1;
    end else begin
      m_done <= (left == 1);
      if (left == 1) begin
        mq <= pq;
        mr <= pr;
        mz <= pz;
      end
      if (start && left <= 1) begin
        left <= (in2 == 0) ? 1 : 5;
        pq   <= (in2 == 0) ? 4'hF : 4'(int'(in1) / int'(in2));
        pr   <= (in2 == 0) ? in1  : 4'(int'(in1) % int'(in2));
        pz   <= (in2 == 0);
      end else if (left > 0) begin
        left <= left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("busy",     int'(busy),     int'(left >= 2));
      chk("done",     int'(done),     int'(m_done));
      chk("quot",     int'(quot),     int'(mq));
      chk("rem",      int'(rem),      int'(mr));
      chk("div_zero", int'(div_zero), int'(mz));
    end
  end

  // One operation; returns edges from the start edge to the edge raising done
  task automatic op(input logic [3:0] a, input logic [3:0] b, output int lat);
    start = 1'b1;
    in1   = a;
    in2   = b;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int busy_cnt;
    rst   = 1'b1;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quot", int'(quot), 0);
    chk("rst_rem",  int'(rem),  0);
    chk("rst_dz",   int'(div_zero), 0);
    rst = 1'b0;
    @(negedge clk);

    // 13 / 3 with busy-cycle count
    start = 1'b1; in1 = 4'd13; in2 = 4'd3;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = int'(busy);
    lat = 0;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
      busy_cnt += int'(busy);
    end
    chk("d13_3_lat",  lat, 5);
    chk("d13_3_busy", busy_cnt, 4);
    chk("d13_3_quot", int'(quot), 4);
    chk("d13_3_rem",  int'(rem), 1);
    chk("d13_3_dz",   int'(div_zero), 0);
    @(negedge clk);
    chk("done_pulse", int'(done), 0);

    op(4'd15, 4'd1, lat);
    chk("d15_1_quot", int'(quot), 15);
    chk("d15_1_rem",  int'(rem), 0);
    op(4'd3, 4'd7, lat);
    chk("d3_7_quot", int'(quot), 0);
    chk("d3_7_rem",  int'(rem), 3);

    // zero divisor: immediate result, never busy
    start = 1'b1; in1 = 4'd9; in2 = 4'd0;
    @(negedge clk);
    start = 1'b0;
    chk("d9_0_busy0", int'(busy), 0);
    @(negedge clk);
    chk("d9_0_done", int'(done), 1);
    chk("d9_0_busy1", int'(busy), 0);
    chk("d9_0_quot", int'(quot), 15);
    chk("d9_0_rem",  int'(rem), 9);
    chk("d9_0_dz",   int'(div_zero), 1);
    @(negedge clk);

    // start held during RUN with changing operands, then back-to-back start in DONE
    start = 1'b1; in1 = 4'd12; in2 = 4'd5;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in1 = 4'($urandom);
      in2 = 4'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    chk("hold_done_early", int'(done), 0);
    start = 1'b1; in1 = 4'd8; in2 = 4'd2;
    @(negedge clk);
    start = 1'b0;
    chk("hold_done", int'(done), 1);
    chk("hold_quot", int'(quot), 2);
    chk("hold_rem",  int'(rem), 2);
    chk("b2b_busy",  int'(busy), 1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 12);
    chk("b2b_lat",  lat, 5);
    chk("b2b_quot", int'(quot), 4);
    chk("b2b_rem",  int'(rem), 0);
    @(negedge clk);

    // reset on the second RUN cycle aborts the division
    start = 1'b1; in1 = 4'd14; in2 = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_quot", int'(quot), 0);
    chk("abort_rem",  int'(rem), 0);
    chk("abort_dz",   int'(div_zero), 0);
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
    end
    op(4'd14, 4'd3, lat);
    chk("d14_3_lat",  lat, 5);
    chk("d14_3_quot", int'(quot), 4);
    chk("d14_3_rem",  int'(rem), 2);

    // exhaustive operand sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        op(4'(a), 4'(b), lat);
        chk("ex_lat",  lat, (b == 0) ? 1 : 5);
        chk("ex_quot", int'(quot), (b == 0) ? 15 : a / b);
        chk("ex_rem",  int'(rem),  (b == 0) ? a  : a % b);
        chk("ex_dz",   int'(div_zero), int'(b == 0));
      end
    end

    // random traffic against the model, including stray starts and resets
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 2) == 0);
      in1   = 4'($urandom);
      in2   = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      @(negedge clk);
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
